// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: line-state encoding, data width and the bit-period helper.
// The receiver imports this same package so both ends agree on framing.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Integer divide; callers must keep the result >= 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle of the UART transmitter.
// The master offers bytes; the slave (transmitter) drives the line and status.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic                      valid;
    logic [UART_DATA_BITS-1:0] data;
    logic                      ready;
    logic                      s_out;
    logic                      done;

    modport master (output valid, output data, input ready, input s_out, input done);
    modport slave  (input valid, input data, output ready, output s_out, output done);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1, tick flags the terminal count.
// clr restarts the period so a new bit always gets a full CLKS_PER_BIT cycles.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; one byte per valid/ready handshake.
// s_out is registered from the next-state values so the line changes on the accept edge.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_if.slave    bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t               r_state, w_state_next;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
    logic [2:0]                r_bit_idx, w_bit_idx_next;
    logic                      r_s_out, w_s_out_next;
    logic                      r_done, w_done_next;
    logic                      w_tick;
    logic                      w_clr;
    logic                      w_accept;

    assign w_accept = bus.valid && (r_state == ST_IDLE);
    assign w_clr    = (w_state_next != r_state);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_s_out_next   = r_s_out;
        w_done_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_out_next = 1'b1;
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_shift_next = bus.data;
                    w_s_out_next = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next   = ST_DATA;
                    w_bit_idx_next = 3'd0;
                    w_s_out_next   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = ST_STOP;
                        w_s_out_next = 1'b1;
                    end else begin
                        // Line takes the bit that becomes shift_reg[0] after this shift.
                        w_shift_next   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_s_out_next   = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                w_s_out_next = 1'b1;
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_s_out_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= 3'd0;
            r_s_out   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_s_out   <= w_s_out_next;
            r_done    <= w_done_next;
        end
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.s_out = r_s_out;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4: a cycles-since-accept frame model checked every
// cycle, plus hand-computed line patterns for the directed scenarios.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if u_if ();

    uart_tx #(
        .CLK_FREQ (40),
        .BAUD     (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int tests = 0;
    int fails = 0;

    // Model: a frame is just "busy for FRAME cycles after accept"; line value is a
    // function of the cycle offset within the frame.
    bit       m_busy;
    int       m_t;
    logic [7:0] m_byte;
    bit       m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_byte <= 8'h00;
            m_done <= 1'b0;
        end else begin
            m_done <= m_busy && (m_t == FRAME - 1);
            if (!m_busy) begin
                if (u_if.valid) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                    m_byte <= u_if.data;
                end
            end else if (m_t == FRAME - 1) begin
                m_busy <= 1'b0;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    function automatic logic exp_line();
        if (!m_busy)          return 1'b1;
        if (m_t < CPB)        return 1'b0;
        if (m_t < 9 * CPB)    return m_byte[(m_t - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("model_s_out", 10'(u_if.s_out), 10'(exp_line()));
        chk("model_ready", 10'(u_if.ready), 10'(!m_busy));
        chk("model_done",  10'(u_if.done),  10'(m_done));
    endtask

    logic cap_s [0:99];
    logic cap_r [0:99];
    logic cap_d [0:99];

    // Records the current sample at index 0, then steps for the rest.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            cap_s[i] = u_if.s_out;
            cap_r[i] = u_if.ready;
            cap_d[i] = u_if.done;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (u_if.ready !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        if (u_if.ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: ready=%0b after %0d cycles, required 1", u_if.ready, k);
        end
    endtask

    task automatic offer(input logic [7:0] b);
        $display("[TB] send 0x%02h", b);
        u_if.valid = 1'b1;
        u_if.data  = b;
        step();
        u_if.valid = 1'b0;
    endtask

    task automatic chk_frame(input string name, input logic [9:0] pat);
        for (int k = 0; k < 10; k++)
            chk(name, 10'(cap_s[CPB * k + 1]), 10'(pat[k]));
    endtask

    initial begin
        logic [9:0] pat;
        logic [7:0] b;
        int cnt;
        int cnt2;

        u_if.valid = 1'b0;
        u_if.data  = 8'h00;
        repeat (3) step();
        rst = 1'b0;

        // 1: idle after reset
        repeat (20) step();
        chk("idle_s_out", 10'(u_if.s_out), 10'd1);
        chk("idle_ready", 10'(u_if.ready), 10'd1);
        chk("idle_done",  10'(u_if.done),  10'd0);

        // 2: 0xA5 frame
        wait_idle();
        offer(8'hA5);
        capture(45);
        pat = 10'b1101001010;
        chk_frame("a5_slot", pat);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 45; i++) begin
            if (cap_r[i] == 1'b0) cnt++;
            if (cap_d[i] == 1'b1) cnt2++;
        end
        chk("a5_busy_cycles", 10'(cnt), 10'd40);
        chk("a5_done_count",  10'(cnt2), 10'd1);
        chk("a5_done_at_40",  10'(cap_d[40]), 10'd1);

        // 3: back-to-back 0x00 then 0xFF with valid held
        wait_idle();
        $display("[TB] send 0x00 then 0xff back-to-back");
        u_if.valid = 1'b1;
        u_if.data  = 8'h00;
        for (int i = 0; i < 90; i++) begin
            step();
            cap_s[i] = u_if.s_out;
            cap_d[i] = u_if.done;
            if (i == 0)  u_if.data  = 8'hFF;
            if (i == 41) u_if.valid = 1'b0;
        end
        cnt = 0;
        for (int i = 4; i < 36; i++) if (cap_s[i]) cnt++;
        chk("b2b_first_ones", 10'(cnt), 10'd0);
        cnt = 0;
        for (int i = 36; i < 41; i++) if (cap_s[i]) cnt++;
        chk("b2b_gap_high", 10'(cnt), 10'd5);
        chk("b2b_second_start", 10'(cap_s[41]), 10'd0);
        cnt = 0;
        for (int i = 45; i < 77; i++) if (cap_s[i]) cnt++;
        chk("b2b_second_ones", 10'(cnt), 10'd32);
        cnt = 0;
        for (int i = 0; i < 90; i++) if (cap_d[i]) cnt++;
        chk("b2b_done_count", 10'(cnt), 10'd2);

        // 4: valid during a frame is ignored
        wait_idle();
        b = 8'($urandom);
        offer(b);
        cnt = 0;
        for (int i = 1; i < 60; i++) begin
            if (i == 10) begin
                u_if.valid = 1'b1;
                u_if.data  = 8'h3C;
            end
            step();
            u_if.valid = 1'b0;
            if (u_if.done) cnt++;
        end
        chk("ignored_done_count", 10'(cnt), 10'd1);
        chk("ignored_line_idle",  10'(u_if.s_out), 10'd1);

        // 5: data changes after accept do not leak into the frame
        wait_idle();
        $display("[TB] send 0x81 (data bus changed to 0xff after accept)");
        u_if.valid = 1'b1;
        u_if.data  = 8'h81;
        step();
        u_if.valid = 1'b0;
        u_if.data  = 8'hFF;
        capture(45);
        b = 8'b1000_0001;
        for (int k = 0; k < 8; k++)
            chk("hold81_bit", 10'(cap_s[CPB * (k + 1) + 1]), 10'(b[k]));

        // 6: asynchronous reset during data bit 3
        wait_idle();
        b = 8'($urandom) & 8'hF7;
        offer(b);
        repeat (17) step();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_s_out", 10'(u_if.s_out), 10'd1);
        chk("async_rst_ready", 10'(u_if.ready), 10'd1);
        repeat (2) step();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (u_if.done) cnt++;
        end
        chk("rst_no_done", 10'(cnt), 10'd0);
        wait_idle();
        offer(8'h5A);
        capture(45);
        pat = 10'b1010110100;
        chk_frame("5a_slot", pat);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            u_if.valid = ($urandom_range(0, 3) == 0);
            u_if.data  = 8'($urandom);
            if (u_if.valid && u_if.ready)
                $display("[TB] rand send 0x%02h", u_if.data);
            step();
        end
        u_if.valid = 1'b0;
        repeat (50) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
